// File: rtl/axi_line_read_responder_pkg.sv
// Shared constants for the cache-line read responder: reset polarity, FSM encodings
// and the stall LFSR seed.
package axi_line_read_responder_pkg;

  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  localparam logic [1:0] RESP_IDLE  = 2'd0;
  localparam logic [1:0] RESP_WAIT  = 2'd1;
  localparam logic [1:0] RESP_BURST = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/axi_line_read_responder_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to inject read bubbles.
// Compiled only when LINE_RESP_STALL_EN is defined.
`ifdef LINE_RESP_STALL_EN
module lfsr8
  import axi_line_read_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    if (step) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule
`endif

// File: rtl/axi_line_read_responder.sv
// Memory-side responder for cache line refills: one address in, a fixed-length burst out.
// Optional random bubble insertion when LINE_RESP_STALL_EN is defined.
module axi_line_read_responder
  import axi_line_read_responder_pkg::*;
#(
  parameter int LINE_OFFSET_WIDTH = 5,
  parameter int MEM_AW            = 10,
  parameter int RD_LATENCY        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic              s_rvalid,
  output logic              s_rlast,
  input  logic              s_rready,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_waddr,
  input  logic [31:0]       bd_wdata
);

  localparam int BEAT_W    = LINE_OFFSET_WIDTH - 2;
  localparam int BEATS     = 1 << BEAT_W;
  localparam int LINE_W    = MEM_AW - BEAT_W;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  // Array holds data XOR its own byte address, so the zero power-up value reads back as {i,2'b00}.
  function automatic logic [31:0] init_word(input logic [MEM_AW-1:0] a);
    init_word = {{(30 - MEM_AW){1'b0}}, a, 2'b00};
  endfunction

  logic [31:0] mem_q [0:MEM_DEPTH-1] = '{default: 32'h0};

  logic [1:0]        state_q,   state_d;
  logic [LINE_W-1:0] line_q,    line_d;
  logic [BEAT_W-1:0] beat_q,    beat_d;
  logic [1:0]        wait_q,    wait_d;
  logic              arready_q, arready_d;
  logic              rvalid_q,  rvalid_d;
  logic              rlast_q,   rlast_d;
  logic [31:0]       rdata_q,   rdata_d;

  logic [BEAT_W-1:0] rd_beat_s;
  logic [MEM_AW-1:0] rd_idx_s;
  logic              load_s;
  logic              stall_s;
  logic              unused_s;

`ifdef LINE_RESP_STALL_EN
  logic [7:0] lfsr_s;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (1'b1),
    .seed (LFSR_SEED),
    .q    (lfsr_s)
  );

  assign stall_s  = lfsr_s[0];
  assign unused_s = ^{s_araddr[31:MEM_AW+2], s_araddr[LINE_OFFSET_WIDTH-1:0], lfsr_s[7:1]};
`else
  assign stall_s  = 1'b0;
  assign unused_s = ^{s_araddr[31:MEM_AW+2], s_araddr[LINE_OFFSET_WIDTH-1:0]};
`endif

  assign rd_idx_s = {line_q, rd_beat_s};

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rd_beat_s = beat_q;
    load_s    = 1'b0;

    case (state_q)
      RESP_IDLE: begin
        arready_d = 1'b1;
        if (s_arvalid && arready_q) begin
          line_d    = s_araddr[MEM_AW+1:LINE_OFFSET_WIDTH];
          beat_d    = '0;
          wait_d    = 2'd0;
          arready_d = 1'b0;
          state_d   = RESP_WAIT;
        end else begin
          state_d = RESP_IDLE;
        end
      end
      RESP_WAIT: begin
        if (wait_q == 2'(RD_LATENCY)) begin
          rd_beat_s = '0;
          load_s    = 1'b1;
          state_d   = RESP_BURST;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      RESP_BURST: begin
        if (rvalid_q) begin
          if (s_rready) begin
            if (beat_q == BEAT_W'(BEATS - 1)) begin
              rvalid_d  = 1'b0;
              rlast_d   = 1'b0;
              arready_d = 1'b1;
              state_d   = RESP_IDLE;
            end else begin
              beat_d    = beat_q + 1'b1;
              rd_beat_s = beat_q + 1'b1;
              if (stall_s) begin
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
              end else begin
                load_s = 1'b1;
              end
            end
          end else begin
            state_d = RESP_BURST;
          end
        end else if (!stall_s) begin
          // Bubble cycle: next beat index already in beat_q
          load_s = 1'b1;
        end else begin
          state_d = RESP_BURST;
        end
      end
      default: begin
        state_d   = RESP_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase

    if (load_s) begin
      rdata_d  = mem_q[rd_idx_s] ^ init_word(rd_idx_s);
      rvalid_d = 1'b1;
      rlast_d  = (rd_beat_s == BEAT_W'(BEATS - 1));
    end else begin
      rdata_d = rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= RESP_IDLE;
      line_q    <= '0;
      beat_q    <= '0;
      wait_q    <= 2'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  // Backdoor port; contents deliberately survive rst
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_q[bd_waddr] <= bd_wdata ^ init_word(bd_waddr);
    end
  end

  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rlast   = rlast_q;
  assign s_rdata   = rdata_q;

endmodule
